turf_axis_rdwr_burst: RTL and testbench
=======================================

# turf_axis_rdwr_burst

Parametrised AXI4-Stream to generic register-bus (en/wr/ack) bridge, successor to the single-word stream rdwr bridge. Adds burst transfers with auto-increment or fixed addressing, a per-beat ack timeout with error substitution, a trailing status word, and `m_axis_tlast` framing. It sits between the host stream path (UDP/PCIe stream) and the TURF register-bus decoders.

## Interface
- `DATA_WIDTH`, 32: stream and bus data width.
- `ADDR_WIDTH`, 28: bus address width. Tag width `TAG_W = DATA_WIDTH-1-ADDR_WIDTH` must be at least 1.
- `LEN_BITS`, 8: burst length field width. A burst is 1 to 2^LEN_BITS beats.
- `ADDR_INC`, 1: address step per beat. 0 gives a fixed (FIFO-style) address.
- `TIMEOUT`, 255: cycles `en_o` may stay high without `ack_i`. 0 disables the timeout.
- `ERR_DATA`, all-ones: read data substituted on a timed-out beat.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH  command/length/write-data stream.
- `s_axis_tvalid`  in  1.
- `s_axis_tready`  out  1.
- `m_axis_tdata`  out  DATA_WIDTH  response stream.
- `m_axis_tvalid`  out  1.
- `m_axis_tready`  in  1.
- `m_axis_tlast`  out  1  high on the status word.
- `en_o`  out  1  bus strobe.
- `wr_o`  out  1  write qualifier.
- `ack_i`  in  1  bus acknowledge.
- `adr_o`  out  ADDR_WIDTH  bus address.
- `dat_i`  in  DATA_WIDTH  read data.
- `dat_o`  out  DATA_WIDTH  write data; equals `s_axis_tdata`.

## Operation
- **Header word.** Bit [DW-1] = 1 for read, 0 for write. Bits [DW-2:ADDR_WIDTH] = tag, echoed unchanged. Bits [ADDR_WIDTH-1:0] = start address.
- **Length word.** Bits [LEN_BITS-1:0] = beats-1. Upper bits are ignored.
- **Read response:** header echo, then N data words, then status.
- **Write response:** header echo, then status. Both are sent after all N write beats complete.
- **Status word.** Bit [DW-1] = any beat timed out. Bits [LEN_BITS:0] = count of beats acked. All other bits are 0.
- **States:**
  - IDLE: on tvalid, capture header → GET_LEN.
  - GET_LEN: on tvalid, capture length and load address → RD_HDR if read, WR_ACK if write.
  - RD_HDR: on tready → RD_ACK.
  - RD_ACK: on ack or timeout → RD_DATA.
  - RD_DATA: on tready → RD_ACK if beats remain, else STATUS.
  - WR_ACK: on ack or timeout → WR_ACK if beats remain, else WR_HDR.
  - WR_HDR: on tready → STATUS.
  - STATUS: on tready → IDLE.
- **Handshakes.**
  - `s_axis_tready` is high in IDLE and GET_LEN.
  - In WR_ACK, `s_axis_tready` is high when tvalid & (ack_i | timeout). A timed-out write word is still consumed.
  - `en_o` = RD_ACK | (WR_ACK & s_axis_tvalid). `wr_o` = WR_ACK.
- **Address update.** Address advances by ADDR_INC after every terminated beat and wraps modulo 2^ADDR_WIDTH.
- **Timeout.**
  - The counter runs only while `en_o` is high and clears on each beat termination.
  - A beat times out on the cycle the count reaches TIMEOUT.
  - If `ack_i` and timeout occur in the same cycle, ack wins and the beat counts as acked.
- **Stray acks.** `ack_i` while `en_o` is low is ignored.
- **Read data.** `dat_i` is registered on ack. `ERR_DATA` is registered on timeout.
- **Reset.** `aresetn` low at any time forces IDLE and clears all counters and flags. Any burst in flight is abandoned with no response.
- **Reset values.** `s_axis_tready`=0 while in reset (1 in IDLE after reset), m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, en_o=0, wr_o=0, adr_o=0.

## Timing
- Read, 1 beat, immediate ack, tready held high:
  - header accepted at cycle 0, length at cycle 1;
  - echo valid at cycle 2;
  - `en_o` at cycle 3;
  - data valid at cycle 4;
  - status+tlast at cycle 5;
  - IDLE at cycle 6.
- Each extra read beat adds 2 cycles.
- Write, 1 beat, data present, immediate ack: `en_o`/`wr_o` at cycle 2, echo at cycle 3, status at cycle 4.
- All m_axis outputs and `adr_o` are registered. `en_o`, `wr_o`, `s_axis_tready` and `dat_o` are combinational from state and inputs.
- m_axis_tdata is stable while tvalid is high and tready is low.

## Structure
- `turf_rdwr_pkg` holds:
  - the state enum;
  - header field offsets: RW bit, tag LSB;
  - status bit positions.
- Sub-module `turf_rdwr_timeout` holds the counter, with inputs `run`, `clr` and output `expired`. TIMEOUT=0 ties `expired` to 0.

## Test plan
- **Single read.** Send 0x8000_0010, 0x0; ack after 2 cycles with 0x1234_5678. Response: 0x8000_0010, 0x1234_5678, 0x0000_0001 (tlast).
- **Write burst.** Send 0x2000_0100, 0x3, then 4 data words; ack each beat. Addresses 0x100–0x103 with `wr_o`=1. Response: 0x2000_0100, 0x0000_0004 (tlast).
- **Fixed-address read.** ADDR_INC=0, read burst of 3. `adr_o` holds constant; 3 data words are returned.
- **Timeout.** TIMEOUT=4, read burst of 2 with ack never asserted on beat 0. `en_o` drops after 4 cycles; data returned is 0xFFFF_FFFF then the real data; status is 0x8000_0001.
- **Backpressure and stray ack.**
  - Hold m_axis_tready low for 10 cycles on each response word: data stays stable and nothing is lost.
  - Pulse ack_i in IDLE: no effect.
- **Reset mid-burst.** Assert aresetn during WR_ACK of beat 2 of 4. All outputs return to reset values; the next command is processed normally.

Source files
------------

// File: rtl/turf_rdwr_pkg.sv
// turf_rdwr_pkg
// Shared definitions for the burst stream <-> register-bus bridge:
//   - bridge FSM state encoding
//   - header field positions (RW bit, tag LSB)
//   - status word bit positions
package turf_rdwr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_LEN,
        S_RD_HDR,
        S_RD_ACK,
        S_RD_DATA,
        S_WR_ACK,
        S_WR_HDR,
        S_STATUS
    } state_e;

    // Header: [DW-1] = 1 read / 0 write, [DW-2:AW] = tag, [AW-1:0] = address
    function automatic int hdr_rw_bit(input int dw);
        return dw - 1;
    endfunction

    function automatic int hdr_tag_lsb(input int aw);
        return aw;
    endfunction

    // Status: [DW-1] = some beat timed out, [LEN_BITS:0] = beats acked
    function automatic int stat_err_bit(input int dw);
        return dw - 1;
    endfunction

    localparam int STAT_CNT_LSB = 0;

endpackage

// File: rtl/turf_rdwr_timeout.sv
// turf_rdwr_timeout
// Per-beat ack watchdog. Counts cycles while run is high; expired fires on
// the TIMEOUT-th consecutive running cycle of a beat. clr restarts the count
// and takes priority over run. TIMEOUT = 0 disables the watchdog.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : bus strobe is active this cycle
//   clr        : current beat terminates this cycle
//   expired    : beat times out this cycle
module turf_rdwr_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = &{1'b0, clk, rst_n, run, clr};
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr)      cnt_d = '0;
                else if (run) cnt_d = cnt_q + CW'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            // cnt_q counts the cycles already spent, so this cycle is number cnt_q+1
            assign expired = run && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/turf_axis_rdwr_burst.sv
// turf_axis_rdwr_burst
// AXI4-Stream to register-bus (en/wr/ack) bridge with bursts.
// Command: header word, length word (beats-1), then write data for writes.
// Response: header echo, read data (reads only), status word with tlast.
// Ports:
//   aclk, aresetn              : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready : command / length / write-data stream in
//   m_axis_tdata/tvalid/tready : response stream out, tlast on status
//   en_o, wr_o, ack_i          : bus strobe, write qualifier, acknowledge
//   adr_o                      : bus address (registered)
//   dat_i                      : bus read data
//   dat_o                      : bus write data (straight from s_axis_tdata)
module turf_axis_rdwr_burst
    import turf_rdwr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    LEN_BITS   = 8,
    parameter int                    ADDR_INC   = 1,
    parameter int                    TIMEOUT    = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = '1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  en_o,
    output logic                  wr_o,
    input  logic                  ack_i,
    output logic [ADDR_WIDTH-1:0] adr_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [LEN_BITS-1:0]   rem_q, rem_d;     // beats left after the current one
    logic [LEN_BITS:0]     cnt_q, cnt_d;     // beats acked
    logic                  err_q, err_d;     // some beat timed out
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] mdat_q, mdat_d;
    logic                  mvld_q, mvld_d;
    logic                  mlst_q, mlst_d;

    logic                  expired;
    logic                  term;
    logic                  m_hs;
    logic [DATA_WIDTH-1:0] status_w;

    // Write strobe waits for data to be present so a beat never fires empty
    assign en_o  = (state_q == S_RD_ACK) || ((state_q == S_WR_ACK) && s_axis_tvalid);
    assign wr_o  = (state_q == S_WR_ACK);
    assign term  = en_o && (ack_i || expired);
    assign m_hs  = mvld_q && m_axis_tready;
    assign dat_o = s_axis_tdata;

    // Write words are consumed exactly when their beat terminates, timed out or not
    assign s_axis_tready = aresetn &&
                           ((state_q == S_IDLE) || (state_q == S_GET_LEN) || (wr_o && term));

    assign m_axis_tdata  = mdat_q;
    assign m_axis_tvalid = mvld_q;
    assign m_axis_tlast  = mlst_q;
    assign adr_o         = adr_q;

    turf_rdwr_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (aclk),
        .rst_n  (aresetn),
        .run    (en_o),
        .clr    (term),
        .expired(expired)
    );

    always_comb begin
        status_w                                      = '0;
        status_w[stat_err_bit(DATA_WIDTH)]            = err_q;
        status_w[STAT_CNT_LSB + LEN_BITS:STAT_CNT_LSB] = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        adr_d   = adr_q;
        mdat_d  = mdat_q;
        mvld_d  = mvld_q;
        mlst_d  = mlst_q;

        // Beat bookkeeping; ack wins over a simultaneous timeout
        if (term) begin
            adr_d = adr_q + ADDR_WIDTH'(ADDR_INC);
            if (ack_i) cnt_d = cnt_q + (LEN_BITS + 1)'(1);
            else       err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    hdr_d   = s_axis_tdata;
                    state_d = S_GET_LEN;
                end
            end
            S_GET_LEN: begin
                if (s_axis_tvalid) begin
                    rem_d = s_axis_tdata[LEN_BITS-1:0];
                    cnt_d = '0;
                    err_d = 1'b0;
                    adr_d = hdr_q[ADDR_WIDTH-1:0];
                    if (hdr_q[hdr_rw_bit(DATA_WIDTH)]) begin
                        mdat_d  = hdr_q;
                        mvld_d  = 1'b1;
                        state_d = S_RD_HDR;
                    end else begin
                        state_d = S_WR_ACK;
                    end
                end
            end
            S_RD_HDR: begin
                if (m_hs) begin
                    mvld_d  = 1'b0;
                    state_d = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                if (term) begin
                    mdat_d  = ack_i ? dat_i : ERR_DATA;
                    mvld_d  = 1'b1;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_hs) begin
                    if (rem_q != '0) begin
                        rem_d   = rem_q - LEN_BITS'(1);
                        mvld_d  = 1'b0;
                        state_d = S_RD_ACK;
                    end else begin
                        mdat_d  = status_w;
                        mlst_d  = 1'b1;
                        state_d = S_STATUS;
                    end
                end
            end
            S_WR_ACK: begin
                if (term) begin
                    if (rem_q == '0) begin
                        mdat_d  = hdr_q;
                        mvld_d  = 1'b1;
                        state_d = S_WR_HDR;
                    end else begin
                        rem_d = rem_q - LEN_BITS'(1);
                    end
                end
            end
            S_WR_HDR: begin
                // cnt_q/err_q already include the final beat here
                if (m_hs) begin
                    mdat_d  = status_w;
                    mlst_d  = 1'b1;
                    state_d = S_STATUS;
                end
            end
            S_STATUS: begin
                if (m_hs) begin
                    mvld_d  = 1'b0;
                    mlst_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            mdat_q  <= '0;
            mvld_q  <= 1'b0;
            mlst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            mdat_q  <= mdat_d;
            mvld_q  <= mvld_d;
            mlst_q  <= mlst_d;
        end
    end

endmodule

// File: tb/tb_turf_axis_rdwr_burst.sv
// Bench for turf_axis_rdwr_burst. Two instances: A (ADDR_INC=1, TIMEOUT=4)
// and B (ADDR_INC=0, TIMEOUT=0); sel routes the stimulus to one of them.
module tb_turf_axis_rdwr_burst;
    localparam int DW = 32, AW = 28, LB = 8, TO_A = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_n, sel;
    logic [DW-1:0] s_tdata, dat_i;
    logic          s_tvalid, m_tready, ack;

    logic [1:0]    i_tvalid, i_ack, i_mready;
    logic [1:0]    o_stready, o_mvalid, o_mlast, o_en, o_wr;
    logic [DW-1:0] o_mdata [2];
    logic [DW-1:0] o_dato  [2];
    logic [AW-1:0] o_adr   [2];

    assign i_tvalid = sel ? {s_tvalid, 1'b0} : {1'b0, s_tvalid};
    assign i_ack    = sel ? {ack, 1'b0}      : {1'b0, ack};
    assign i_mready = sel ? {m_tready, 1'b0} : {1'b0, m_tready};

    logic          d_en, d_wr, d_stready, d_mvalid, d_mlast;
    logic [DW-1:0] d_mdata, d_dato;
    logic [AW-1:0] d_adr;
    assign d_en      = o_en[sel];
    assign d_wr      = o_wr[sel];
    assign d_stready = o_stready[sel];
    assign d_mvalid  = o_mvalid[sel];
    assign d_mlast   = o_mlast[sel];
    assign d_mdata   = o_mdata[sel];
    assign d_dato    = o_dato[sel];
    assign d_adr     = o_adr[sel];

    turf_axis_rdwr_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_BITS(LB),
                           .ADDR_INC(1), .TIMEOUT(TO_A)) u_a (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(i_tvalid[0]), .s_axis_tready(o_stready[0]),
        .m_axis_tdata(o_mdata[0]), .m_axis_tvalid(o_mvalid[0]), .m_axis_tready(i_mready[0]),
        .m_axis_tlast(o_mlast[0]), .en_o(o_en[0]), .wr_o(o_wr[0]), .ack_i(i_ack[0]),
        .adr_o(o_adr[0]), .dat_i(dat_i), .dat_o(o_dato[0]));

    turf_axis_rdwr_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_BITS(LB),
                           .ADDR_INC(0), .TIMEOUT(0)) u_b (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(i_tvalid[1]), .s_axis_tready(o_stready[1]),
        .m_axis_tdata(o_mdata[1]), .m_axis_tvalid(o_mvalid[1]), .m_axis_tready(i_mready[1]),
        .m_axis_tlast(o_mlast[1]), .en_o(o_en[1]), .wr_o(o_wr[1]), .ack_i(i_ack[1]),
        .adr_o(o_adr[1]), .dat_i(dat_i), .dat_o(o_dato[1]));

    int checks = 0, errors = 0, cyc = 0, hdr_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus slave model state
    int lat = 0, lat_fix = 0, encnt = 0, beat = 0, drop_beat = -1;
    bit lat_rand = 0, stray = 0, ovr_en = 0;
    logic [DW-1:0] ovr_val = '0;
    logic [AW-1:0] acc_adr[$];
    bit            acc_wr[$], acc_to[$];
    logic [DW-1:0] acc_dat[$];

    // response sink state
    bit bp_mode = 0, rnd_rdy = 0, held_v = 0;
    int stall = 0;
    logic [DW-1:0] held_d, resp_d[$];
    bit            resp_l[$];
    int            resp_cyc[$];

    function automatic logic [DW-1:0] rdfn(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction
    function automatic int cur_to();  return sel ? 0 : TO_A; endfunction
    function automatic int cur_inc(); return sel ? 0 : 1;    endfunction

    // Bus slave: acks a beat after lat strobe cycles unless the beat is the
    // one chosen to be dropped; a dropped beat ends after cur_to() cycles.
    initial begin
        ack = 1'b0; dat_i = '0;
        forever begin
            @(negedge clk); #4;
            dat_i = $urandom;
            if (d_en) begin
                ack = (beat != drop_beat) && (encnt >= lat);
                if (ack) begin
                    dat_i = ovr_en ? ovr_val : rdfn(d_adr);
                    acc_adr.push_back(d_adr); acc_wr.push_back(d_wr);
                    acc_dat.push_back(d_dato); acc_to.push_back(1'b0);
                    beat++; encnt = 0;
                    lat = lat_rand ? int'($urandom_range(0, 2)) : lat_fix;
                end else begin
                    encnt++;
                    if (cur_to() != 0 && encnt == cur_to()) begin
                        acc_adr.push_back(d_adr); acc_wr.push_back(d_wr);
                        acc_dat.push_back(d_dato); acc_to.push_back(1'b1);
                        beat++; encnt = 0;
                    end
                end
            end else begin
                ack = stray;
            end
        end
    end

    // Response sink with stability check while stalled
    initial begin
        m_tready = 1'b0;
        forever begin
            @(negedge clk); #4;
            if (bp_mode) m_tready = d_mvalid && (stall >= 10);
            else         m_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (held_v) begin
                checks++;
                if (d_mvalid !== 1'b1 || d_mdata !== held_d) begin
                    errors++;
                    $display("FAIL stall_stable: got vld=%b data=%h exp vld=1 data=%h", d_mvalid, d_mdata, held_d);
                end
            end
            if (d_mvalid === 1'b1) begin
                if (m_tready) begin
                    resp_d.push_back(d_mdata); resp_l.push_back(d_mlast); resp_cyc.push_back(cyc);
                    stall = 0; held_v = 0;
                end else begin
                    stall++; held_v = 1; held_d = d_mdata;
                end
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish exp finish");
        $fatal(1, "watchdog");
    end

    // Entered at a negedge; returns at the negedge after the accepting edge.
    task automatic put_word(input logic [DW-1:0] w, input int gap, output bit ok, output int hc);
        s_tvalid = 1'b0;
        repeat (gap) @(negedge clk);
        s_tvalid = 1'b1; s_tdata = w; ok = 0; hc = 0;
        for (int n = 0; n < 300; n++) begin
            #6;
            if (d_stready === 1'b1) begin ok = 1; hc = cyc; end
            @(negedge clk);
            if (ok) break;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic clear_bench();
        acc_adr.delete(); acc_wr.delete(); acc_dat.delete(); acc_to.delete();
        resp_d.delete(); resp_l.delete(); resp_cyc.delete();
        beat = 0; encnt = 0; held_v = 0; stall = 0;
    endtask

    task automatic run_cmd(input bit rd, input logic [2:0] tag, input logic [AW-1:0] a,
                           input int n, input int drop, input int gmax, input string nm);
        logic [DW-1:0] hdr, lw, w;
        logic [DW-1:0] wd[$], exq[$];
        logic [AW-1:0] ea;
        bit ok, eto, tob;
        int hc, nack, nexp;
        clear_bench();
        drop_beat = drop;
        lat = lat_rand ? int'($urandom_range(0, 2)) : lat_fix;
        hdr = {rd, tag, a};
        put_word(hdr, 0, ok, hc); hdr_cyc = hc;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_hdr_accept: got none exp accept", nm); end
        lw = $urandom; lw[LB-1:0] = LB'(n - 1);
        put_word(lw, 0, ok, hc);
        if (!rd)
            for (int i = 0; i < n; i++) begin
                w = $urandom; wd.push_back(w);
                put_word(w, int'($urandom_range(0, gmax)), ok, hc);
                checks++;
                if (!ok) begin errors++; $display("FAIL %s_wdata_accept: got none exp beat %0d", nm, i); end
            end
        nexp = rd ? n + 2 : 2;
        for (int c = 0; c < 4000 && resp_d.size() < nexp; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (resp_d.size() != nexp) begin
            errors++; $display("FAIL %s_resp_count: got %0d exp %0d", nm, resp_d.size(), nexp);
        end
        checks++;
        if (acc_adr.size() != n) begin
            errors++; $display("FAIL %s_beat_count: got %0d exp %0d", nm, acc_adr.size(), n);
        end
        nack = 0; eto = 0;
        exq.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            ea  = AW'(a + AW'(i * cur_inc()));
            tob = (i == drop);
            if (tob) eto = 1; else nack++;
            if (rd) exq.push_back(tob ? 32'hFFFF_FFFF : (ovr_en ? ovr_val : rdfn(ea)));
            if (i < acc_adr.size()) begin
                checks++;
                if (acc_adr[i] !== ea || acc_wr[i] !== !rd || acc_to[i] !== tob ||
                    (!rd && acc_dat[i] !== wd[i])) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got adr=%h wr=%b to=%b dat=%h exp adr=%h wr=%b to=%b dat=%h",
                             nm, i, acc_adr[i], acc_wr[i], acc_to[i], acc_dat[i], ea, !rd, tob,
                             rd ? acc_dat[i] : wd[i]);
                end
            end
        end
        exq.push_back({eto, 31'(nack)});
        for (int i = 0; i < nexp && i < resp_d.size(); i++) begin
            checks++;
            if (resp_d[i] !== exq[i] || resp_l[i] !== (i == nexp - 1)) begin
                errors++;
                $display("FAIL %s_word%0d: got %h last=%b exp %h last=%b", nm, i, resp_d[i], resp_l[i],
                         exq[i], (i == nexp - 1));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({d_stready, d_mvalid, d_mlast, d_en, d_wr} !== 5'b0 || d_mdata !== '0 || d_adr !== '0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b lst=%b en=%b wr=%b dat=%h adr=%h exp all 0",
                     d_stready, d_mvalid, d_mlast, d_en, d_wr, d_mdata, d_adr);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (d_stready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", d_stready); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        sel = 0; ovr_en = 1; ovr_val = 32'h1234_5678; lat_fix = 2; lat_rand = 0;
        run_cmd(1'b1, 3'b000, 28'h10, 1, -1, 0, "single_read");
        ovr_en = 0;
    endtask

    task automatic test_write_burst();
        sel = 0; lat_fix = 1; lat_rand = 0;
        run_cmd(1'b0, 3'b010, 28'h100, 4, -1, 2, "write_burst");
    endtask

    task automatic test_timing();
        sel = 0; lat_fix = 0; lat_rand = 0; rnd_rdy = 0; bp_mode = 0;
        run_cmd(1'b1, 3'b101, 28'h0ABC, 1, -1, 0, "timing_rd");
        checks++;
        if (resp_cyc.size() != 3 || resp_cyc[0] - hdr_cyc != 2 || resp_cyc[1] - hdr_cyc != 4 ||
            resp_cyc[2] - hdr_cyc != 5) begin
            errors++;
            $display("FAIL timing_rd: got %0d words first at +%0d exp echo +2 data +4 status +5",
                     resp_cyc.size(), resp_cyc.size() > 0 ? resp_cyc[0] - hdr_cyc : -1);
        end
        run_cmd(1'b0, 3'b011, 28'h0DEF, 1, -1, 0, "timing_wr");
        checks++;
        if (resp_cyc.size() != 2 || resp_cyc[0] - hdr_cyc != 3 || resp_cyc[1] - hdr_cyc != 4) begin
            errors++;
            $display("FAIL timing_wr: got %0d words first at +%0d exp echo +3 status +4",
                     resp_cyc.size(), resp_cyc.size() > 0 ? resp_cyc[0] - hdr_cyc : -1);
        end
    endtask

    task automatic test_fixed_addr();
        sel = 1; lat_rand = 1;
        run_cmd(1'b1, 3'b001, 28'h0000_4C0, 3, -1, 0, "fixed_rd");
        run_cmd(1'b0, 3'b110, 28'h0000_4C4, 3, -1, 2, "fixed_wr");
        sel = 0; lat_rand = 0;
    endtask

    task automatic test_timeout();
        sel = 0; lat_fix = 1; lat_rand = 0;
        run_cmd(1'b1, 3'b000, 28'h200, 2, 0, 0, "timeout_rd");
        run_cmd(1'b0, 3'b100, 28'h300, 3, 1, 1, "timeout_wr");
    endtask

    task automatic test_backpressure();
        sel = 0; bp_mode = 1; lat_rand = 1;
        run_cmd(1'b1, 3'b111, 28'h0FF_FF00, 3, -1, 0, "bp_rd");
        run_cmd(1'b0, 3'b010, 28'h0FF_FF10, 2, -1, 1, "bp_wr");
        bp_mode = 0; lat_rand = 0;
    endtask

    task automatic test_stray_ack();
        sel = 0; stray = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #6;
            checks++;
            if (d_en !== 1'b0 || d_mvalid !== 1'b0 || d_stready !== 1'b1) begin
                errors++;
                $display("FAIL stray_ack_idle: got en=%b vld=%b rdy=%b exp en=0 vld=0 rdy=1", d_en, d_mvalid, d_stready);
            end
        end
        @(negedge clk); stray = 0;
        lat_fix = 1;
        run_cmd(1'b1, 3'b001, 28'h500, 2, -1, 0, "after_stray");
    endtask

    task automatic test_reset_mid();
        bit ok; int hc;
        sel = 0; lat_fix = 0; lat_rand = 0;
        clear_bench(); drop_beat = -1; lat = 0;
        put_word({1'b0, 3'b011, 28'h0000_700}, 0, ok, hc);
        put_word(32'h0000_0003, 0, ok, hc);
        put_word(32'hCAFE_0000, 0, ok, hc);
        lat = 5;
        s_tvalid = 1'b1; s_tdata = 32'hCAFE_0001;
        @(negedge clk); #1;
        checks++;
        if (d_en !== 1'b1 || d_wr !== 1'b1 || d_adr !== 28'h0000_701) begin
            errors++;
            $display("FAIL mid_burst_beat2: got en=%b wr=%b adr=%h exp en=1 wr=1 adr=0000701", d_en, d_wr, d_adr);
        end
        rst_n = 1'b0; s_tvalid = 1'b0;
        #1;
        checks++;
        if ({d_stready, d_mvalid, d_mlast, d_en, d_wr} !== 5'b0 || d_mdata !== '0 || d_adr !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: got rdy=%b vld=%b lst=%b en=%b wr=%b dat=%h adr=%h exp all 0",
                     d_stready, d_mvalid, d_mlast, d_en, d_wr, d_mdata, d_adr);
        end
        clear_bench();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_bench();
        lat_fix = 1;
        run_cmd(1'b0, 3'b011, 28'h0000_700, 2, -1, 0, "post_reset_wr");
        run_cmd(1'b1, 3'b011, 28'h0000_700, 2, -1, 0, "post_reset_rd");
    endtask

    task automatic test_random();
        bit rd; int n, drop;
        logic [AW-1:0] a;
        rnd_rdy = 1; lat_rand = 1;
        for (int k = 0; k < 24; k++) begin
            sel  = k[0];
            rd   = $urandom_range(0, 1);
            n    = $urandom_range(1, 6);
            a    = (k % 4 == 2) ? 28'hFFF_FFFE : AW'($urandom);
            drop = (!sel && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_cmd(rd, 3'($urandom), a, n, drop, 3, "random");
        end
        rnd_rdy = 0; lat_rand = 0; sel = 0;
    endtask

    initial begin
        sel = 0; s_tvalid = 0; s_tdata = '0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_write_burst();
        test_timing();
        test_fixed_addr();
        test_timeout();
        test_backpressure();
        test_stray_ack();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
